// File: rtl/fft_pkg.sv
`default_nettype none
// fft_pkg: FSM state encoding and default frame/sample sizes shared by the
// FFT stream adapter and its frame buffer.
package fft_pkg;

  localparam int FFT_DEF_N  = 8;
  localparam int FFT_DEF_DW = 24;

  typedef enum logic [2:0] {
    ST_FILL  = 3'd0,
    ST_PUSH  = 3'd1,
    ST_RUN   = 3'd2,
    ST_FETCH = 3'd3,
    ST_SEND  = 3'd4
  } fft_state_t;

endpackage
`default_nettype wire

// File: rtl/fft_frame_buffer.sv
`default_nettype none
// fft_frame_buffer: N-entry register file holding one frame of {re, im}
// samples; one synchronous write port, one combinational read port.
module fft_frame_buffer
  import fft_pkg::*;
#(
  parameter int N  = FFT_DEF_N,
  parameter int DW = FFT_DEF_DW,
  localparam int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_re,
  input  logic [DW-1:0] wr_im,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_re,
  output logic [DW-1:0] rd_im
);

  logic [2*DW-1:0] mem [N];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= {wr_re, wr_im};
    end
  end

  assign rd_re = mem[rd_addr][2*DW-1:DW];
  assign rd_im = mem[rd_addr][DW-1:0];

endmodule
`default_nettype wire

// File: rtl/fft_stream_adapter.sv
`default_nettype none
// fft_stream_adapter: buffers an N-sample input frame, loads it into an FFT
// core, waits for completion, then streams results. FFT_OUT_SCALE_EN enables 1/N output scaling.
module fft_stream_adapter
  import fft_pkg::*;
#(
  parameter int N       = FFT_DEF_N,
  parameter int DW      = FFT_DEF_DW,
  parameter int RD_LAT  = 1,
  parameter int TIMEOUT = 1023,
  localparam int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_re,
  input  logic [DW-1:0] s_im,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_re,
  output logic [DW-1:0] m_im,
  output logic          m_last,
  output logic          core_initial_en,
  output logic [DW-1:0] core_din_re,
  output logic [DW-1:0] core_din_im,
  output logic [AW-1:0] core_read_addr,
  input  logic [DW-1:0] core_dout_re,
  input  logic [DW-1:0] core_dout_im,
  input  logic          core_fft_finish,
  output logic          busy,
  output logic          err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int LW = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

  fft_state_t    state;
  logic [AW-1:0] cnt;
  logic [AW-1:0] addr;
  logic [TW-1:0] run_cnt;
  logic [LW-1:0] lat_cnt;
  logic          finish_q;
  logic          err_q;
  logic [DW-1:0] out_re;
  logic [DW-1:0] out_im;
  logic          out_last;

  logic          fill_beat;
  logic          finish_rise;
  logic [DW-1:0] buf_re;
  logic [DW-1:0] buf_im;
  logic [DW-1:0] res_re;
  logic [DW-1:0] res_im;

  assign fill_beat   = (state == ST_FILL) && s_valid;
  assign finish_rise = core_fft_finish && !finish_q;

  // Fill writes and push reads share cnt; they never happen in the same state.
  fft_frame_buffer #(
    .N  (N),
    .DW (DW)
  ) u_frame_buffer (
    .clk     (clk),
    .wr_en   (fill_beat),
    .wr_addr (cnt),
    .wr_re   (s_re),
    .wr_im   (s_im),
    .rd_addr (cnt),
    .rd_re   (buf_re),
    .rd_im   (buf_im)
  );

`ifdef FFT_OUT_SCALE_EN
  // Divide by N with round-half-up; one guard bit keeps the bias add exact.
  function automatic logic [DW-1:0] scale_round(input logic [DW-1:0] x);
    logic [DW:0] half;
    logic [DW:0] sum;
    logic [DW:0] shr;
    half = (DW + 1)'(1) << (AW - 1);
    sum  = {x[DW-1], x} + half;
    shr  = $signed(sum) >>> AW;
    return shr[DW-1:0];
  endfunction

  assign res_re = scale_round(core_dout_re);
  assign res_im = scale_round(core_dout_im);
`else
  assign res_re = core_dout_re;
  assign res_im = core_dout_im;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_FILL;
      cnt      <= '0;
      addr     <= '0;
      run_cnt  <= '0;
      lat_cnt  <= '0;
      finish_q <= 1'b0;
      err_q    <= 1'b0;
      out_re   <= '0;
      out_im   <= '0;
      out_last <= 1'b0;
    end else begin
      finish_q <= core_fft_finish;
      case (state)
        ST_FILL: begin
          if (s_valid) begin
            if (cnt == LAST_IDX) begin
              cnt   <= '0;
              state <= ST_PUSH;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ST_PUSH: begin
          if (cnt == LAST_IDX) begin
            cnt     <= '0;
            run_cnt <= '0;
            state   <= ST_RUN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RUN: begin
          // A finish level left high from a previous frame is not an edge.
          if (finish_rise) begin
            addr    <= '0;
            lat_cnt <= '0;
            state   <= ST_FETCH;
          end else if (run_cnt == TW'(TIMEOUT - 1)) begin
            err_q <= 1'b1;
            state <= ST_FILL;
          end else begin
            run_cnt <= run_cnt + 1'b1;
          end
        end
        ST_FETCH: begin
          if (lat_cnt == LW'(RD_LAT)) begin
            out_re   <= res_re;
            out_im   <= res_im;
            out_last <= (addr == LAST_IDX);
            state    <= ST_SEND;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        ST_SEND: begin
          if (m_ready) begin
            if (addr == LAST_IDX) begin
              addr  <= '0;
              state <= ST_FILL;
            end else begin
              addr    <= addr + 1'b1;
              lat_cnt <= '0;
              state   <= ST_FETCH;
            end
          end
        end
        default: state <= ST_FILL;
      endcase
    end
  end

  assign s_ready         = (state == ST_FILL);
  assign busy            = (state != ST_FILL);
  assign err             = err_q;
  assign core_initial_en = (state == ST_PUSH);
  assign core_din_re     = (state == ST_PUSH) ? buf_re : '0;
  assign core_din_im     = (state == ST_PUSH) ? buf_im : '0;
  assign core_read_addr  = addr;
  assign m_valid         = (state == ST_SEND);
  assign m_re            = out_re;
  assign m_im            = out_im;
  assign m_last          = out_last;

endmodule
`default_nettype wire

// File: tb/tb_fft_stream_adapter.sv
`default_nettype none
// tb_fft_stream_adapter: randomized frames through the adapter against a
// stand-in FFT core; expected beats are queued and popped by an output monitor.
module tb_fft_stream_adapter;

  localparam int N       = 8;
  localparam int DW      = 24;
  localparam int RD_LAT  = 1;
  localparam int TIMEOUT = 1023;
  localparam int AW      = 3;
  localparam int FIN_DLY = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_re = '0;
  logic [DW-1:0] s_im = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_re;
  logic [DW-1:0] m_im;
  logic          m_last;
  logic          core_initial_en;
  logic [DW-1:0] core_din_re;
  logic [DW-1:0] core_din_im;
  logic [AW-1:0] core_read_addr;
  logic [DW-1:0] core_dout_re = '0;
  logic [DW-1:0] core_dout_im = '0;
  logic          core_fft_finish = 1'b0;
  logic          busy;
  logic          err;

  int checks = 0;
  int errors = 0;

  // Stimulus control shared between main sequence, feeder and models.
  int feed_left  = 0;
  int valid_pct  = 100;
  int ready_mode = 0;
  bit stuck      = 1'b0;
  bit hs_in      = 1'b0;
  int dir_re[$];
  int dir_im[$];

  // Reference-model state.
  int pend_re[$];
  int pend_im[$];
  int exp_re[$];
  int exp_im[$];
  bit exp_last[$];
  int frame_re[N];
  int frame_im[N];
  int load_re[N];
  int load_im[N];
  int mem_re[N];
  int mem_im[N];
  int push_idx  = 0;
  int push_run  = 0;
  int acc_beats = 0;
  int fin_cnt   = -1;
  logic [AW-1:0] addr_q = '0;

  always #5 clk = ~clk;

  fft_stream_adapter #(
    .N       (N),
    .DW      (DW),
    .RD_LAT  (RD_LAT),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .s_valid         (s_valid),
    .s_ready         (s_ready),
    .s_re            (s_re),
    .s_im            (s_im),
    .m_valid         (m_valid),
    .m_ready         (m_ready),
    .m_re            (m_re),
    .m_im            (m_im),
    .m_last          (m_last),
    .core_initial_en (core_initial_en),
    .core_din_re     (core_din_re),
    .core_din_im     (core_din_im),
    .core_read_addr  (core_read_addr),
    .core_dout_re    (core_dout_re),
    .core_dout_im    (core_dout_im),
    .core_fft_finish (core_fft_finish),
    .busy            (busy),
    .err             (err)
  );

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Stand-in core transform: bin k takes re from sample N-1-k, im = im[k] + re[k].
  function automatic void core_fn(input int re[N], input int im[N], input int k,
                                  output int ore, output int oim);
    ore = re[N-1-k];
    oim = im[k] + re[k];
  endfunction

  function automatic int out_scale(input int x);
`ifdef FFT_OUT_SCALE_EN
    return (x + N / 2) >>> AW;
`else
    return x;
`endif
  endfunction

  function automatic int rnd();
    return int'($urandom_range(0, 1 << 20)) - (1 << 19);
  endfunction

  // Input handshakes, core load port and core completion model.
  always @(negedge clk) begin
    int pr, pi, r, i;
    if (!rst) begin
      pend_re.delete(); pend_im.delete();
      exp_re.delete(); exp_im.delete(); exp_last.delete();
      push_idx = 0; push_run = 0; acc_beats = 0; fin_cnt = -1;
      core_fft_finish = 1'b0; hs_in = 1'b0;
    end else begin
      hs_in = s_valid && s_ready;
      if (hs_in) begin
        pend_re.push_back(int'($signed(s_re)));
        pend_im.push_back(int'($signed(s_im)));
        acc_beats++;
      end
      if (busy && s_valid) check("s_ready_low_while_busy", s_ready, 0);
      if (core_initial_en) begin
        if (push_run == 0) begin
          check("beats_per_frame", acc_beats, N);
          acc_beats = 0;
          core_fft_finish = 1'b0;
          fin_cnt = -1;
        end
        push_run++;
        if (pend_re.size() == 0) begin
          checks++; errors++;
          $display("FAIL push_without_input din_re=%0d required=none", $signed(core_din_re));
          pr = 0; pi = 0;
        end else begin
          pr = pend_re.pop_front();
          pi = pend_im.pop_front();
          check("core_din_re", $signed(core_din_re), pr);
          check("core_din_im", $signed(core_din_im), pi);
        end
        frame_re[push_idx] = pr;
        frame_im[push_idx] = pi;
        load_re[push_idx]  = int'($signed(core_din_re));
        load_im[push_idx]  = int'($signed(core_din_im));
        push_idx = (push_idx + 1) % N;
        if (push_idx == 0) begin
          for (int k = 0; k < N; k++) begin
            core_fn(load_re, load_im, k, r, i);
            mem_re[k] = r;
            mem_im[k] = i;
          end
          fin_cnt = FIN_DLY;
        end
      end else begin
        check("core_din_idle", core_din_re | core_din_im, 0);
        if (push_run > 0) begin
          check("push_len", push_run, N);
          push_run = 0;
        end
        if (fin_cnt > 0) begin
          fin_cnt--;
          if (fin_cnt == 0) begin
            fin_cnt = -1;
            if (!stuck) begin
              core_fft_finish = 1'b1;
              for (int k = 0; k < N; k++) begin
                core_fn(frame_re, frame_im, k, r, i);
                exp_re.push_back(out_scale(r));
                exp_im.push_back(out_scale(i));
                exp_last.push_back(k == N - 1);
              end
            end
          end
        end
      end
      addr_q = core_read_addr;
    end
  end

  // Core read port: address captured mid-cycle, data valid one cycle later.
  always @(posedge clk) begin
    core_dout_re <= DW'(mem_re[addr_q]);
    core_dout_im <= DW'(mem_im[addr_q]);
  end

  // Output monitor: scoreboard pop, hold-under-stall and beat spacing.
  bit            prev_stall = 1'b0;
  logic [DW-1:0] held_re, held_im;
  logic          held_last;
  int            gap = -1;

  always @(negedge clk) begin
    if (!rst) begin
      prev_stall = 1'b0;
      gap = -1;
    end else if (m_valid) begin
      if (prev_stall) begin
        check("hold_m_re", $signed(m_re), $signed(held_re));
        check("hold_m_im", $signed(m_im), $signed(held_im));
        check("hold_m_last", m_last, held_last);
      end
      if (gap >= 0) begin
        check("beat_gap_within_limit", (gap <= RD_LAT + 1) ? 1 : 0, 1);
        gap = -1;
      end
      if (m_ready) begin
        if (exp_re.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat m_re=%0d required=no_beat", $signed(m_re));
        end else begin
          check("m_re", $signed(m_re), exp_re.pop_front());
          check("m_im", $signed(m_im), exp_im.pop_front());
          check("m_last", m_last, exp_last.pop_front());
        end
        prev_stall = 1'b0;
        gap = m_last ? -1 : 0;
      end else begin
        prev_stall = 1'b1;
        held_re = m_re; held_im = m_im; held_last = m_last;
      end
    end else begin
      if (prev_stall) begin
        checks++; errors++;
        $display("FAIL m_valid_dropped_under_stall actual=0 required=1");
        prev_stall = 1'b0;
      end
      if (gap >= 0) gap++;
    end
  end

  // Input feeder: offers beats until feed_left are consumed.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (s_valid && hs_in) begin
        s_valid = 1'b0;
        feed_left--;
      end
      if (!s_valid && feed_left > 0 && ($urandom_range(0, 99) < valid_pct)) begin
        if (dir_re.size() > 0) begin
          s_re = DW'(dir_re.pop_front());
          s_im = DW'(dir_im.pop_front());
        end else begin
          s_re = DW'(rnd());
          s_im = DW'(rnd());
        end
        s_valid = 1'b1;
      end
    end
  end

  // Output backpressure: 0 = always ready, 1 = 1,0,0,1 pattern, else random.
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: m_ready = 1'b1;
        1: begin
          m_ready = ((ph % 4) == 0) || ((ph % 4) == 3);
          ph++;
        end
        default: m_ready = ($urandom_range(0, 1) == 1);
      endcase
    end
  end

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(feed_left == 0 && !s_valid && !busy && exp_re.size() == 0 && fin_cnt < 0)
               && n < budget);
    check(name, (n < budget) ? 1 : 0, 1);
  endtask

  task automatic run_frames(input string name, input int frames, input int vpct, input int rmode);
    valid_pct  = vpct;
    ready_mode = rmode;
    feed_left  = frames * N;
    wait_done(name, 500 * frames);
  endtask

  initial begin
    int cnt;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_s_ready", s_ready, 1);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_last", m_last, 0);
    check("rst_m_re", m_re, 0);
    check("rst_m_im", m_im, 0);
    check("rst_core_initial_en", core_initial_en, 0);
    check("rst_core_read_addr", core_read_addr, 0);
    check("rst_err", err, 0);

    // Ramp frame 0..7 on re.
    for (int k = 0; k < N; k++) begin
      dir_re.push_back(k);
      dir_im.push_back(0);
    end
    run_frames("ramp_frame_done", 1, 100, 0);

    run_frames("backpressure_done", 2, 100, 1);
    run_frames("random_done", 4, 60, 2);

    // Rounding boundary: bins 0 and 1 carry +12 and -12.
    for (int k = 0; k < N; k++) begin
      dir_re.push_back((k == N - 1) ? 12 : (k == N - 2) ? -12 : 0);
      dir_im.push_back(0);
    end
    run_frames("round_frame_done", 1, 100, 0);

    run_frames("held_valid_done", 2, 100, 0);

    // Watchdog: core never finishes.
    stuck = 1'b1;
    valid_pct = 100;
    feed_left = N;
    cnt = 0;
    while (!core_initial_en && cnt < 500) begin @(negedge clk); cnt++; end
    while (core_initial_en && cnt < 500) begin @(negedge clk); cnt++; end
    check("timeout_reached_push", (cnt < 500) ? 1 : 0, 1);
    cnt = 0;
    while (busy && cnt < 2 * TIMEOUT) begin @(negedge clk); cnt++; end
    check("timeout_run_cycles", cnt, TIMEOUT);
    check("timeout_err", err, 1);
    check("timeout_s_ready", s_ready, 1);
    check("timeout_busy", busy, 0);
    check("timeout_m_valid", m_valid, 0);
    repeat (FIN_DLY + 2) @(negedge clk);
    stuck = 1'b0;
    run_frames("after_timeout_done", 1, 80, 2);
    check("err_sticky", err, 1);

    // Reset during the third PUSH cycle.
    valid_pct = 100;
    ready_mode = 0;
    feed_left = N;
    cnt = 0;
    begin
      int seen;
      seen = 0;
      while (seen < 3 && cnt < 500) begin
        @(negedge clk);
        cnt++;
        if (core_initial_en) seen++;
      end
    end
    check("midpush_reached", (cnt < 500) ? 1 : 0, 1);
    #2 rst = 1'b0;
    @(negedge clk);
    check("midpush_core_initial_en", core_initial_en, 0);
    check("midpush_m_valid", m_valid, 0);
    check("midpush_s_ready", s_ready, 1);
    check("midpush_err_cleared", err, 0);
    #2 rst = 1'b1;
    run_frames("after_reset_done", 1, 100, 2);
    run_frames("final_random_done", 2, 70, 2);
    check("final_err", err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
`default_nettype wire

// File: doc/fft_stream_adapter.md
FFT_STREAM_ADAPTER -- requirements
Module: fft_stream_adapter

Interface
REQ-001 Parameter N, default 8: transform length; frame size in samples.
REQ-002 Parameter DW, default 24: signed sample width, re and im.
REQ-003 Parameter RD_LAT, default 1: cycles from core_read_addr to valid core_dout_re/im.
REQ-004 Parameter TIMEOUT, default 1023: maximum RUN cycles before error.
REQ-005 Port clk, in, 1: single clock; all logic rising-edge.
REQ-006 Port rst, in, 1: reset, synchronous, active-low.
REQ-007 Ports s_valid in 1, s_ready out 1, s_re in DW, s_im in DW: input sample stream.
REQ-008 Ports m_valid out 1, m_ready in 1, m_re out DW, m_im out DW, m_last out 1: result stream.
REQ-009 Ports core_initial_en out 1, core_din_re out DW, core_din_im out DW: FFT core load port.
REQ-010 Ports core_read_addr out log2(N), core_dout_re in DW, core_dout_im in DW, core_fft_finish in 1: FFT core result port.
REQ-011 Port busy out 1: high in every state except FILL; port err out 1: sticky timeout flag.

Function
REQ-012 FSM states FILL, PUSH, RUN, FETCH, SEND; reset state FILL.
REQ-013 FILL: s_ready=1; each s_valid&s_ready beat writes the local buffer at index cnt, cnt increments; after beat N-1, go to PUSH with cnt=0.
REQ-014 PUSH: core_initial_en=1 for exactly N consecutive cycles, core_din = buffer[cnt], cnt increments; after cnt=N-1, go to RUN.
REQ-015 core_initial_en SHALL be 0 in every state except PUSH; core_din holds 0 outside PUSH.
REQ-016 RUN: core_fft_finish is registered each cycle; a 0->1 transition ends RUN and enters FETCH with addr=0; a level already high on RUN entry does not count.
REQ-017 RUN watchdog: if no rising edge within TIMEOUT cycles, set err=1 and go to FILL; err clears only on reset.
REQ-018 FETCH: drive core_read_addr=addr; after RD_LAT cycles, capture core_dout into m_re/m_im and go to SEND.
REQ-019 SEND: m_valid=1; m_re/m_im/m_last stable until m_ready; m_last=1 iff addr=N-1.
REQ-020 On m_valid&m_ready: if addr<N-1, increment addr, return to FETCH; else go to FILL.
REQ-021 Throughput: one output beat per at most RD_LAT+2 cycles; m_valid deasserted during FETCH.
REQ-022 s_ready=0 outside FILL; input beats offered then are not consumed.
REQ-023 Output ordering equals core address order 0..N-1; no reordering in this block.
REQ-024 Simultaneous s_valid and frame completion: the Nth beat is accepted and PUSH begins next cycle.

Reset
REQ-025 On rst=0 at a clock edge: state=FILL, cnt=addr=0, err=0, busy=0, m_valid=0, m_last=0, m_re=m_im=0, core_initial_en=0, core_read_addr=0, s_ready=1 on the following cycle.
REQ-026 Reset mid-frame (any state) discards buffered and pending output data; no partial frame is emitted.

Configuration
REQ-027 Macro FFT_OUT_SCALE_EN defined: m_re/m_im = core_dout arithmetic-shifted right by log2(N), rounded half-up (add 2^(log2(N)-1) before shift, DW+1-bit intermediate, result fits DW).
REQ-028 Macro FFT_OUT_SCALE_EN undefined: m_re/m_im = core_dout unmodified; no rounding logic synthesized.

Structure
REQ-029 Shared package fft_pkg holds the FSM state enumeration, default DW, and default N constants.
REQ-030 One sub-module, fft_frame_buffer: N x 2*DW register file with one write port (FILL) and one read port (PUSH).

Verification
REQ-031 Frame 0..7 on re (im=0), core model finish 20 cycles after PUSH -> core_initial_en high 8 cycles with din 0..7, then 8 m beats in address order, m_last on beat 8 only.
REQ-032 Backpressure: m_ready toggles 1,0,0,1 repeatedly -> each m_re held stable while m_ready=0, no beat lost or duplicated.
REQ-033 core_fft_finish stuck low -> after 1023 RUN cycles err=1, state FILL, s_ready=1, no m_valid.
REQ-034 rst low at cycle 3 of PUSH -> next cycle core_initial_en=0, m_valid=0, s_ready=1; new full frame processed correctly.
REQ-035 FFT_OUT_SCALE_EN defined, core output re=+12, -12 -> m_re=+2, -1 (half-up rounding); undefined -> +12, -12.
REQ-036 s_valid held high throughout two frames -> exactly 8 beats accepted per frame, s_ready low from PUSH until last output beat accepted.
